// File: rtl/banner_pkg.sv
// Shared types for the text banner overlay: screen geometry, character codes,
// the 5x7 font, the message table and the animation state encoding.
// Purely declarative; no latency, no backpressure.
package banner_pkg;

   localparam int OLED_W      = 96;
   localparam int OLED_H      = 64;
   localparam int OLED_PIXELS = OLED_W * OLED_H;
   localparam int MSG_SLOTS   = 8;

   typedef enum logic [3:0] {
      CH_BLANK, CH_K, CH_O, CH_P, CH_W, CH_I, CH_N, CH_S,
      CH_F, CH_G, CH_H, CH_T, CH_1, CH_2
   } char_e;

   typedef enum logic [1:0] {ST_IDLE, ST_SLIDE, ST_HOLD, ST_SHOW} state_e;

   // Result of mapping a banner-relative coordinate onto a character cell.
   // ok = inside the banner, on a glyph column (not the gap) and non-blank.
   typedef struct packed {
      logic       ok;
      char_e      chr;
      logic [2:0] row;
      logic [2:0] gcol;
   } cell_t;

   // 7 rows of 5 bits, row 0 in the top bits; bit 4 of a row is column 0.
   function automatic logic [34:0] font_glyph(input char_e c);
      case (c)
         CH_K:    return {5'b10001, 5'b10010, 5'b10100, 5'b11000, 5'b10100, 5'b10010, 5'b10001};
         CH_O:    return {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
         CH_P:    return {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
         CH_W:    return {5'b10001, 5'b10001, 5'b10001, 5'b10101, 5'b10101, 5'b10101, 5'b01010};
         CH_I:    return {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
         CH_N:    return {5'b10001, 5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001};
         CH_S:    return {5'b01111, 5'b10000, 5'b10000, 5'b01110, 5'b00001, 5'b00001, 5'b11110};
         CH_F:    return {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
         CH_G:    return {5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01111};
         CH_H:    return {5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
         CH_T:    return {5'b11111, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
         CH_1:    return {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
         CH_2:    return {5'b01110, 5'b10001, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b11111};
         default: return 35'd0;
      endcase
   endfunction

   // Message table: 0 "KO", 1 "P1 WINS", 2 "P2 WINS", 3 "FIGHT".
   function automatic char_e msg_char(input logic [1:0] sel, input logic [2:0] idx);
      char_e m [MSG_SLOTS];
      m = '{default: CH_BLANK};
      case (sel)
         2'd0: begin
            m[0] = CH_K; m[1] = CH_O;
         end
         2'd1: begin
            m[0] = CH_P; m[1] = CH_1; m[3] = CH_W; m[4] = CH_I; m[5] = CH_N; m[6] = CH_S;
         end
         2'd2: begin
            m[0] = CH_P; m[1] = CH_2; m[3] = CH_W; m[4] = CH_I; m[5] = CH_N; m[6] = CH_S;
         end
         default: begin
            m[0] = CH_F; m[1] = CH_I; m[2] = CH_G; m[3] = CH_H; m[4] = CH_T;
         end
      endcase
      return m[idx];
   endfunction

endpackage

// File: rtl/text_banner_overlay_if.sv
// Bundle of the banner's control, pixel-query and result signals.
// master drives ticks/requests/pixel_index; slave returns colour/hit/status.
// No flow control: every signal is sampled or updated each clock.
interface text_banner_overlay_if;
   import banner_pkg::*;

   logic        frame_tick;
   logic        start;
   logic        abort;
   logic [1:0]  text_sel;
   logic [12:0] pixel_index;
   logic [15:0] oled_colour;
   logic        pixel_hit;
   logic        busy;
   logic        done;

   modport master (
      output frame_tick, start, abort, text_sel, pixel_index,
      input  oled_colour, pixel_hit, busy, done
   );

   modport slave (
      input  frame_tick, start, abort, text_sel, pixel_index,
      output oled_colour, pixel_hit, busy, done
   );
endinterface

// File: rtl/glyph_rom_5x7.sv
// Combinational 5x7 glyph ROM: char code + row in, 5 pixel bits out (MSB = column 0).
// Latency: 0 (pure logic). Backpressure: none.
// Ports: i_chr char code, i_row glyph row 0..6 (7 reads as blank), o_bits row pixels.
module glyph_rom_5x7
   import banner_pkg::*;
(
   input  char_e       i_chr,
   input  logic [2:0]  i_row,
   output logic [4:0]  o_bits
);
   logic [34:0] w_glyph;

   always_comb begin
      w_glyph = font_glyph(i_chr);
      o_bits  = 5'd0;
      if (i_row <= 3'd6)
         o_bits = 5'(w_glyph >> (6'd5 * (6'd6 - 6'(i_row))));
   end
endmodule

// File: rtl/text_banner_overlay.sv
// Animated text banner (slide-in, blink, steady) overlaid on the 96x64 OLED pixel stream.
// Latency: 1 clk from pixel_index to oled_colour/pixel_hit. Backpressure: none, one pixel per clock.
// Ports: clk, rst_n (async active-low), bus.slave: frame_tick/start/abort/text_sel/pixel_index in,
// oled_colour/pixel_hit/busy/done out. Optional drop shadow with `define TEXT_BANNER_SHADOW_EN.
module text_banner_overlay
   import banner_pkg::*;
#(
   parameter int          MAX_CHARS   = 8,
   parameter int          SCALE       = 1,
   parameter logic [15:0] FG_COLOUR   = 16'hFFFF,
   parameter logic [15:0] BG_COLOUR   = 16'h0000,
   parameter int          HOME_X      = 42,
   parameter int          HOME_Y      = 3,
   parameter int          SLIDE_STEP  = 4,
   parameter int          HOLD_FRAMES = 90,
   parameter int          BLINK_HALF  = 8
)(
   input  logic                  clk,
   input  logic                  rst_n,
   text_banner_overlay_if.slave  bus
);
   localparam logic [7:0]  START_X    = 8'(OLED_W);
   localparam logic [7:0]  HOME_X_B   = 8'(HOME_X);
   localparam logic [7:0]  STEP_B     = 8'(SLIDE_STEP);
   localparam logic [7:0]  LAST_CNT   = 8'(HOLD_FRAMES - 1);
   localparam logic [7:0]  BLINK_B    = 8'(BLINK_HALF);
   localparam logic [15:0] SHADOW_COL = 16'h4208;

   state_e      r_state, w_state_nx;
   logic [7:0]  r_cur_x, w_cur_x_nx;
   logic [7:0]  r_cnt,   w_cnt_nx;
   logic [1:0]  r_sel,   w_sel_nx;
   logic        r_done,  w_done_nx;
   logic [15:0] r_colour;
   logic        r_hit;

   // ---------------- animation FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cur_x <= START_X;
         r_cnt   <= 8'd0;
         r_sel   <= 2'd0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cur_x <= w_cur_x_nx;
         r_cnt   <= w_cnt_nx;
         r_sel   <= w_sel_nx;
         r_done  <= w_done_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cur_x_nx = r_cur_x;
      w_cnt_nx   = r_cnt;
      w_sel_nx   = r_sel;
      w_done_nx  = 1'b0;
      if (bus.abort) begin
         // abort outranks everything, including a simultaneous start
         w_state_nx = ST_IDLE;
         w_cur_x_nx = START_X;
      end else begin
         case (r_state)
            ST_IDLE, ST_SHOW: begin
               // a start in the same cycle as a tick swallows the tick
               if (bus.start) begin
                  w_sel_nx   = bus.text_sel;
                  w_cur_x_nx = START_X;
                  w_state_nx = ST_SLIDE;
               end
            end
            ST_SLIDE: begin
               if (bus.frame_tick) begin
                  // compare before subtracting so the step can never wrap below zero
                  if ({1'b0, r_cur_x} <= ({1'b0, HOME_X_B} + {1'b0, STEP_B})) begin
                     w_cur_x_nx = HOME_X_B;
                     w_cnt_nx   = 8'd0;
                     w_state_nx = ST_HOLD;
                  end else begin
                     w_cur_x_nx = r_cur_x - STEP_B;
                  end
               end
            end
            ST_HOLD: begin
               if (bus.frame_tick) begin
                  if (r_cnt == LAST_CNT) begin
                     w_state_nx = ST_SHOW;
                     w_done_nx  = 1'b1;
                  end else begin
                     w_cnt_nx = r_cnt + 8'd1;
                  end
               end
            end
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   // ---------------- render path ----------------
   // Map a banner-relative coordinate to its character cell; all divisors are constants.
   function automatic cell_t locate(input logic signed [7:0] rx, input logic signed [7:0] ry,
                                    input logic [1:0] sel);
      cell_t      c;
      logic [7:0] col;
      logic [7:0] ci;
      col    = $unsigned(rx) / 8'(SCALE);
      ci     = col / 8'd6;
      c.gcol = 3'(col % 8'd6);
      c.row  = 3'($unsigned(ry) / 8'(SCALE));
      c.chr  = msg_char(sel, 3'(ci));
      c.ok   = !rx[7] && !ry[7]
            && (int'(rx) < MAX_CHARS * 6 * SCALE) && (int'(ry) < 7 * SCALE)
            && (ci < 8'(MSG_SLOTS)) && (c.gcol < 3'd5) && (c.chr != CH_BLANK);
      return c;
   endfunction

   logic [12:0]        w_x13, w_y13;
   logic signed [7:0]  w_rel_x, w_rel_y;
   logic               w_on_screen, w_visible, w_hit, w_sh_hit;
   cell_t              w_cell;
   logic [4:0]         w_rom_bits;

   // x/y come from the same index, so a glyph running past x=95 is simply
   // never addressed: clipping falls out without any wrap onto the next row.
   assign w_y13       = bus.pixel_index / 13'(OLED_W);
   assign w_x13       = bus.pixel_index - (w_y13 * 13'(OLED_W));
   assign w_rel_x     = 8'(w_x13) - r_cur_x;
   assign w_rel_y     = 8'(w_y13) - 8'(HOME_Y);
   assign w_on_screen = bus.pixel_index < 13'(OLED_PIXELS);
   assign w_visible   = (r_state != ST_IDLE)
                     && ((r_state != ST_HOLD) || (((r_cnt / BLINK_B) % 8'd2) == 8'd0));
   assign w_cell      = locate(w_rel_x, w_rel_y, r_sel);

   glyph_rom_5x7 u_rom (
      .i_chr  (w_cell.chr),
      .i_row  (w_cell.row),
      .o_bits (w_rom_bits)
   );

   assign w_hit = w_on_screen && w_visible && w_cell.ok
               && (|(w_rom_bits & (5'b10000 >> w_cell.gcol)));

`ifdef TEXT_BANNER_SHADOW_EN
   // Shadow: the pixel one up and one left would be text.
   cell_t      w_sh_cell;
   logic [4:0] w_sh_bits;

   assign w_sh_cell = locate(w_rel_x - 8'sd1, w_rel_y - 8'sd1, r_sel);

   glyph_rom_5x7 u_rom_shadow (
      .i_chr  (w_sh_cell.chr),
      .i_row  (w_sh_cell.row),
      .o_bits (w_sh_bits)
   );

   assign w_sh_hit = w_on_screen && w_visible && (w_x13 != 13'd0) && (w_y13 != 13'd0)
                  && w_sh_cell.ok && (|(w_sh_bits & (5'b10000 >> w_sh_cell.gcol)));
`else
   assign w_sh_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_colour <= BG_COLOUR;
         r_hit    <= 1'b0;
      end else if (w_hit) begin
         r_colour <= FG_COLOUR;
         r_hit    <= 1'b1;
      end else if (w_sh_hit) begin
         r_colour <= SHADOW_COL;
         r_hit    <= 1'b1;
      end else begin
         r_colour <= BG_COLOUR;
         r_hit    <= 1'b0;
      end
   end

   assign bus.oled_colour = r_colour;
   assign bus.pixel_hit   = r_hit;
   assign bus.busy        = (r_state == ST_SLIDE) || (r_state == ST_HOLD);
   assign bus.done        = r_done;
endmodule

// File: tb/tb_text_banner_overlay.sv
// Directed self-checking bench for text_banner_overlay (default build, shadow disabled).
// Inputs are driven on the falling edge, registered outputs sampled on the following falling edge.
// Each scenario task makes its own comparisons against hand-derived values.
module tb_text_banner_overlay;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [15:0] obs_colour;
   logic        obs_hit;

   text_banner_overlay_if bus();

   text_banner_overlay dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---- stimulus helpers (no checking inside) ----
   task automatic tick();
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_start(input logic [1:0] sel);
      @(negedge clk) begin bus.start = 1'b1; bus.text_sel = sel; end
      @(negedge clk) bus.start = 1'b0;
   endtask

   task automatic do_abort();
      @(negedge clk) bus.abort = 1'b1;
      @(negedge clk) bus.abort = 1'b0;
   endtask

   task automatic probe(input logic [12:0] idx);
      @(negedge clk) bus.pixel_index = idx;
      @(negedge clk) begin obs_colour = bus.oled_colour; obs_hit = bus.pixel_hit; end
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      rst_n = 1'b0;
      bus.frame_tick = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
      bus.text_sel = 2'd0; bus.pixel_index = 13'd330;
      repeat (3) @(negedge clk);
      checks++; if (bus.oled_colour !== 16'h0000) begin errors++; $display("FAIL reset_colour got=%h exp=0000", bus.oled_colour); end
      checks++; if ({bus.pixel_hit, bus.busy, bus.done} !== 3'b000) begin errors++; $display("FAIL reset_flags got hit/busy/done=%b exp=000", {bus.pixel_hit, bus.busy, bus.done}); end
      rst_n = 1'b1;
      probe(13'd330);
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL idle_no_hit got=%b exp=0", obs_hit); end
   endtask

   task automatic test_slide();
      do_start(2'd0);
      ticks(13);                            // cur_x = 96 - 13*4 = 44
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL slide_busy got=%b exp=1", bus.busy); end
      probe(13'd332);                       // x44,y3: K row0 col0
      checks++; if (obs_colour !== 16'hFFFF || obs_hit !== 1'b1) begin errors++; $display("FAIL slide_x44 got=%h/%b exp=FFFF/1", obs_colour, obs_hit); end
      probe(13'd331);
      checks++; if (obs_colour !== 16'h0000 || obs_hit !== 1'b0) begin errors++; $display("FAIL slide_x43 got=%h/%b exp=0000/0", obs_colour, obs_hit); end
      tick();                               // 14th: cur_x clamps to 42, HOLD, counter 0
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_busy got=%b exp=1", bus.busy); end
      probe(13'd330);
      checks++; if (obs_colour !== 16'hFFFF || obs_hit !== 1'b1) begin errors++; $display("FAIL hold_330 got=%h/%b exp=FFFF/1", obs_colour, obs_hit); end
      probe(13'd331);
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL hold_331 got=%b exp=0", obs_hit); end
      probe(13'd334);                       // K row0 col4
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL hold_k_col4 got=%b exp=1", obs_hit); end
      probe(13'd335);                       // inter-character gap
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL hold_gap got=%b exp=0", obs_hit); end
      probe(13'd336);                       // O row0 col0 = 0
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL hold_o_col0 got=%b exp=0", obs_hit); end
      probe(13'd337);                       // O row0 col1 = 1
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL hold_o_col1 got=%b exp=1", obs_hit); end
      probe(13'd6200);
      checks++; if (obs_hit !== 1'b0 || obs_colour !== 16'h0000) begin errors++; $display("FAIL offscreen got=%h/%b exp=0000/0", obs_colour, obs_hit); end
   endtask

   task automatic test_blink_done();
      ticks(8);                             // counter 8: blink off
      probe(13'd330);
      checks++; if (obs_colour !== 16'h0000 || obs_hit !== 1'b0) begin errors++; $display("FAIL blink_off got=%h/%b exp=0000/0", obs_colour, obs_hit); end
      ticks(8);                             // counter 16: on
      probe(13'd330);
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL blink_on got=%b exp=1", obs_hit); end
      ticks(73);                            // counter 89 (phase 11, off)
      checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL hold_89 got busy/done=%b%b exp=10", bus.busy, bus.done); end
      probe(13'd330);
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL blink_89 got=%b exp=0", obs_hit); end
      @(negedge clk) bus.frame_tick = 1'b1; // 90th tick in HOLD
      @(negedge clk) bus.frame_tick = 1'b0;
      checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL done_pulse got done/busy=%b%b exp=10", bus.done, bus.busy); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_width got=%b exp=0", bus.done); end
      probe(13'd330);
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL show_on got=%b exp=1", obs_hit); end
      ticks(8);
      probe(13'd330);
      checks++; if (obs_hit !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL show_steady got hit/busy=%b%b exp=10", obs_hit, bus.busy); end
   endtask

   task automatic test_start_in_hold();
      do_start(2'd1);                       // restart from SHOW: "P1 WINS"
      ticks(14);
      do_start(2'd2);                       // ignored in HOLD
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL p1_busy got=%b exp=1", bus.busy); end
      probe(13'd330);                       // P row0 col0
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL p1_p got=%b exp=1", obs_hit); end
      probe(13'd337);                       // '1' row0 col1 = 0 ('2' would be 1)
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL sel_kept got=%b exp=0", obs_hit); end
      probe(13'd338);
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL p1_digit got=%b exp=1", obs_hit); end
      probe(13'd342);                       // blank slot 2
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL blank_slot got=%b exp=0", obs_hit); end
      probe(13'd348);                       // W row0 col0 in slot 3
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL p1_w got=%b exp=1", obs_hit); end
   endtask

   task automatic test_abort();
      int hits;
      do_abort();
      do_start(2'd0);
      ticks(2);                             // cur_x = 88
      probe(13'd376);
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL slide_x88 got=%b exp=1", obs_hit); end
      @(negedge clk) begin bus.start = 1'b1; bus.abort = 1'b1; end
      @(negedge clk) begin bus.start = 1'b0; bus.abort = 1'b0; end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
      hits = 0;
      for (int i = 0; i < 6144; i++) begin
         @(negedge clk) begin
            if (bus.pixel_hit === 1'b1) hits++;
            bus.pixel_index = 13'(i);
         end
      end
      @(negedge clk) if (bus.pixel_hit === 1'b1) hits++;
      checks++; if (hits !== 0) begin errors++; $display("FAIL abort_scan hits=%0d exp=0", hits); end
   endtask

   task automatic test_clip();
      int hits;
      @(negedge clk) begin bus.start = 1'b1; bus.text_sel = 2'd3; bus.frame_tick = 1'b1; end
      @(negedge clk) begin bus.start = 1'b0; bus.frame_tick = 1'b0; end
      tick();                               // cur_x = 92 (simultaneous tick was dropped)
      probe(13'd379);                       // x91: left of banner
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL clip_x91 got=%b exp=0", obs_hit); end
      probe(13'd380);
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL clip_x92 got=%b exp=1", obs_hit); end
      probe(13'd383);
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL clip_x95 got=%b exp=1", obs_hit); end
      probe(13'd476);                       // F row1 col0
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL clip_r1c0 got=%b exp=1", obs_hit); end
      probe(13'd477);
      checks++; if (obs_hit !== 1'b0) begin errors++; $display("FAIL clip_r1c1 got=%b exp=0", obs_hit); end
      hits = 0;
      for (int i = 0; i < 5; i++) begin
         probe(13'(288 + i)); if (obs_hit === 1'b1) hits++;
         probe(13'(384 + i)); if (obs_hit === 1'b1) hits++;
      end
      checks++; if (hits !== 0) begin errors++; $display("FAIL clip_nowrap hits=%0d exp=0", hits); end
   endtask

   task automatic test_reset_mid();
      do_abort();
      do_start(2'd0);
      ticks(14);
      probe(13'd330);
      checks++; if (obs_hit !== 1'b1) begin errors++; $display("FAIL pre_reset got=%b exp=1", obs_hit); end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.oled_colour !== 16'h0000 || bus.pixel_hit !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset got=%h/%b/%b exp=0000/0/0", bus.oled_colour, bus.pixel_hit, bus.busy); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      probe(13'd330);
      checks++; if (obs_hit !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle got hit/busy=%b%b exp=00", obs_hit, bus.busy); end
      do_start(2'd0);
      tick();                               // cur_x = 92
      probe(13'd380);
      checks++; if (obs_hit !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL post_reset_run got hit/busy=%b%b exp=11", obs_hit, bus.busy); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_slide();
      test_blink_done();
      test_start_in_hold();
      test_abort();
      test_clip();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
